// File: rtl/sio_rx.sv
// UART receiver: 8N1 (8E1 with SIO_RX_PARITY_EN) deserialiser with a small receive FIFO.
// Ports: clk, reset(async hi), rxd, brdiv -> rdata/rvalid/rready pop, ferr/perr pulses, ovf sticky (clr).
module sio_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int BRDIV_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rxd,
  input  logic [BRDIV_W-1:0] brdiv,
  output logic [7:0]         rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic               ferr,
  output logic               ovf,
  output logic               perr,
  input  logic               clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, BRK
  } st_t;

  st_t               st;
  logic              s1, rxs, rxs_d;
  logic [BRDIV_W-1:0] tcnt;
  logic              tick, fall, restart, mid;
  logic [3:0]        phase;
  logic [2:0]        bitn;
  logic [7:0]        sh;
  logic              push, pop, full, wr;
  logic [AW:0]       wptr, rptr;
  logic [7:0]        mem [FIFO_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rxd;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end

  assign fall    = rxs_d & ~rxs;
  assign restart = (st == IDLE) && fall;
  // >= so a brdiv lowered mid-count still wraps promptly
  assign tick    = (tcnt >= brdiv);
  assign mid     = tick && (phase == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tcnt <= '0;
    else if (restart || tick)
      tcnt <= '0;
    else
      tcnt <= tcnt + BRDIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      phase <= '0;
      bitn  <= '0;
      sh    <= '0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
    end else begin
      ferr <= 1'b0;
      perr <= 1'b0;
      unique case (st)
        IDLE: begin
          phase <= '0;
          if (fall) st <= START;
        end
        START: if (tick) begin
          if (phase == 4'd7) begin
            phase <= '0;
            bitn  <= '0;
            st    <= rxs ? IDLE : DATA;
          end else begin
            phase <= phase + 4'd1;
          end
        end
        DATA: if (tick) begin
          phase <= phase + 4'd1;
          if (phase == 4'd15) begin
            sh   <= {rxs, sh[7:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) begin
`ifdef SIO_RX_PARITY_EN
              st <= PAR;
`else
              st <= STOP;
`endif
            end
          end
        end
        PAR: if (tick) begin
          phase <= phase + 4'd1;
          if (phase == 4'd15) begin
`ifdef SIO_RX_PARITY_EN
            // even parity: data plus parity bit must have an even 1 count
            perr <= ^{sh, rxs};
`endif
            st <= STOP;
          end
        end
        STOP: if (tick) begin
          phase <= phase + 4'd1;
          if (phase == 4'd15) begin
            // leave at mid-stop so a back-to-back start edge is seen
            if (rxs) begin
              st <= IDLE;
            end else begin
              ferr <= 1'b1;
              st   <= BRK;
            end
          end
        end
        BRK: if (rxs) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign push   = (st == STOP) && mid && rxs;
  assign rvalid = (wptr != rptr);
  assign full   = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = rvalid & rready;
  assign wr     = push && (!full || pop);
  assign rdata  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr[AW-1:0]] <= sh;
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (clr)
        ovf <= 1'b0;
    end
  end

endmodule
